// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with the HI/LO register pair.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up in a final cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] busW,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic        r_is_div;
  logic        r_sign_q;
  logic        r_sign_r;
  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_mplier;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_div;
  logic [31:0] r_orig_a;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod_fix;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // op[0]=0 selects the signed variants (MULT, DIV)
  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed && busA[31]) ? (~busA + 32'd1) : busA;
  assign w_abs_b  = (w_signed && busB[31]) ? (~busB + 32'd1) : busB;

  // 33-bit partial remainder: previous remainder shifted left with the next dividend bit.
  // When w_ge holds the difference is below the divisor, so 32 bits hold it exactly.
  assign w_shift = {r_rem, r_quot[31]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[31:0] - r_div;

  assign w_prod_fix = r_sign_q ? (~r_acc + 64'd1) : r_acc;
  assign w_q_fix    = r_sign_q ? (~r_quot + 32'd1) : r_quot;
  assign w_r_fix    = r_sign_r ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == 6'd31) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_mcand  <= 64'd0;
      r_acc    <= 64'd0;
      r_mplier <= 32'd0;
      r_rem    <= 32'd0;
      r_quot   <= 32'd0;
      r_div    <= 32'd0;
      r_orig_a <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= busW;
          if (lo_we) r_lo <= busW;
          if (start) begin
            r_cnt    <= 6'd0;
            r_is_div <= op[1];
            r_sign_q <= w_signed & (busA[31] ^ busB[31]);
            r_sign_r <= w_signed & op[1] & busA[31];
            r_mcand  <= {32'd0, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= 64'd0;
            r_quot   <= w_abs_a;
            r_div    <= w_abs_b;
            r_rem    <= 32'd0;
            r_orig_a <= busA;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_is_div) begin
            r_rem  <= w_ge ? w_diff : w_shift[31:0];
            r_quot <= {r_quot[30:0], w_ge};
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= {r_mcand[62:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_is_div) begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end else if (r_div == 32'd0) begin
            r_hi <= r_orig_a;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
